ide_host_ctrl: RTL and testbench

- Host-side (initiator) controller for the IDE disk device's 8-register, 8-bit bus: ce_n/oe_n/we_n strobes, 3-bit address, status/command at register 7, data port at register 0, LBA bytes at registers 3..5.
- Accepts a one-sector read or write request on a simple request port, then sequences the register programming, status polling and byte transfer.
- Moves sector data through valid/ready byte streams.
- Sits between the CPU-side DMA/microcode glue and the disk device.

---
 rtl/ide_host_ctrl_if.sv | 34 +++
 rtl/ide_host_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ide_host_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ide_host_ctrl_if.sv
// Signal bundle between the IDE host controller, its request/stream clients and the disk register bus.
// The controller takes the master view; the requester and device side take the slave view.
interface ide_host_ctrl_if;
    logic        start;
    logic        rw;
    logic [23:0] lba;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [2:0]  address;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;

    modport master (
        input  start, rw, lba, rd_ready, wr_data, wr_valid, bus_din,
        output busy, done, error, rd_data, rd_valid, wr_ready,
        output ce_n, oe_n, we_n, address, bus_dout
    );

    modport slave (
        output start, rw, lba, rd_ready, wr_data, wr_valid, bus_din,
        input  busy, done, error, rd_data, rd_valid, wr_ready,
        input  ce_n, oe_n, we_n, address, bus_dout
    );
endinterface

// File: rtl/ide_host_ctrl.sv
// IDE host controller: programs LBA and command registers, polls status bit3, then streams
// one sector through the data port. Every bus access is SETUP / STROBE x ACCESS_CYCLES / HOLD.
module ide_host_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int SECTOR_BYTES  = 512,
    parameter int POLL_LIMIT    = 1024
) (
    input  logic            clk,
    input  logic            arst_n,
    ide_host_ctrl_if.master bus
);
    localparam int BW = $clog2(SECTOR_BYTES + 1);
    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam int SW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [BW-1:0] BYTES_END   = BW'(SECTOR_BYTES);
    localparam logic [BW-1:0] BYTES_LAST  = BW'(SECTOR_BYTES - 1);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_LIMIT - 1);
    localparam logic [SW-1:0] STROBE_LAST = SW'(ACCESS_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LBA0, S_LBA1, S_LBA2, S_CMD,
        S_WAIT_BUSY, S_XFER, S_WAIT_DONE, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t          state_reg;
    phase_t          phase_reg;
    logic [SW-1:0]   strobe_cnt_reg;
    logic [BW-1:0]   byte_cnt_reg;
    logic [PW-1:0]   poll_cnt_reg;
    logic            rw_reg;
    logic [23:0]     lba_reg;
    logic            is_read_reg;
    logic            status_bit_reg;

    // What the current state would put on the bus if an access starts this cycle.
    logic            acc_go;
    logic            acc_read;
    logic [2:0]      acc_addr;
    logic [7:0]      acc_data;

    always_comb begin
        acc_go   = 1'b0;
        acc_read = 1'b1;
        acc_addr = 3'd7;
        acc_data = 8'h00;
        case (state_reg)
            S_LBA0: begin
                acc_go = 1'b1; acc_read = 1'b0; acc_addr = 3'd3; acc_data = lba_reg[7:0];
            end
            S_LBA1: begin
                acc_go = 1'b1; acc_read = 1'b0; acc_addr = 3'd4; acc_data = lba_reg[15:8];
            end
            S_LBA2: begin
                acc_go = 1'b1; acc_read = 1'b0; acc_addr = 3'd5; acc_data = lba_reg[23:16];
            end
            S_CMD: begin
                acc_go = 1'b1; acc_read = 1'b0; acc_addr = 3'd7;
                acc_data = rw_reg ? 8'h30 : 8'h20;
            end
            S_WAIT_BUSY, S_WAIT_DONE: acc_go = 1'b1;
            S_XFER: begin
                acc_addr = 3'd0;
                acc_read = !rw_reg;
                acc_data = bus.wr_data;
                // Reads wait for the consumer to drain rd_data; writes wait for a stream byte.
                if (byte_cnt_reg != BYTES_END)
                    acc_go = rw_reg ? (bus.wr_valid && bus.wr_ready) : !bus.rd_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= S_IDLE;
            phase_reg      <= PH_GAP;
            strobe_cnt_reg <= '0;
            byte_cnt_reg   <= '0;
            poll_cnt_reg   <= '0;
            rw_reg         <= 1'b0;
            lba_reg        <= '0;
            is_read_reg    <= 1'b0;
            status_bit_reg <= 1'b0;
            bus.ce_n       <= 1'b1;
            bus.oe_n       <= 1'b1;
            bus.we_n       <= 1'b1;
            bus.address    <= 3'd0;
            bus.bus_dout   <= 8'h00;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.rd_data    <= 8'h00;
            bus.rd_valid   <= 1'b0;
            bus.wr_ready   <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            if (bus.rd_valid && bus.rd_ready)
                bus.rd_valid <= 1'b0;

            case (phase_reg)
                PH_GAP: begin
                    if (acc_go) begin
                        bus.ce_n    <= 1'b0;
                        bus.address <= acc_addr;
                        is_read_reg <= acc_read;
                        phase_reg   <= PH_SETUP;
                        if (!acc_read)
                            bus.bus_dout <= acc_data;
                        if (state_reg == S_XFER && rw_reg)
                            bus.wr_ready <= 1'b0;
                    end
                    case (state_reg)
                        S_IDLE: begin
                            if (bus.start) begin
                                rw_reg    <= bus.rw;
                                lba_reg   <= bus.lba;
                                bus.busy  <= 1'b1;
                                state_reg <= S_LBA0;
                            end
                        end
                        S_XFER: begin
                            if (byte_cnt_reg == BYTES_END && !bus.rd_valid)
                                state_reg <= S_WAIT_DONE;
                        end
                        S_DONE, S_ERROR: state_reg <= S_IDLE;
                        default: ;
                    endcase
                end

                PH_SETUP: begin
                    if (is_read_reg)
                        bus.oe_n <= 1'b0;
                    else
                        bus.we_n <= 1'b0;
                    strobe_cnt_reg <= '0;
                    phase_reg      <= PH_STROBE;
                end

                PH_STROBE: begin
                    if (strobe_cnt_reg == STROBE_LAST) begin
                        bus.oe_n  <= 1'b1;
                        bus.we_n  <= 1'b1;
                        phase_reg <= PH_HOLD;
                        if (is_read_reg) begin
                            status_bit_reg <= bus.bus_din[3];
                            if (state_reg == S_XFER) begin
                                bus.rd_data  <= bus.bus_din;
                                bus.rd_valid <= 1'b1;
                            end
                        end
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    bus.ce_n  <= 1'b1;
                    phase_reg <= PH_GAP;
                    case (state_reg)
                        S_LBA0: state_reg <= S_LBA1;
                        S_LBA1: state_reg <= S_LBA2;
                        S_LBA2: state_reg <= S_CMD;
                        S_CMD: begin
                            state_reg    <= S_WAIT_BUSY;
                            poll_cnt_reg <= '0;
                        end
                        S_WAIT_BUSY: begin
                            if (status_bit_reg) begin
                                state_reg    <= S_XFER;
                                poll_cnt_reg <= '0;
                                byte_cnt_reg <= '0;
                                bus.wr_ready <= rw_reg;
                            end else if (poll_cnt_reg == POLL_LAST) begin
                                state_reg <= S_ERROR;
                                bus.busy  <= 1'b0;
                                bus.error <= 1'b1;
                            end else begin
                                poll_cnt_reg <= poll_cnt_reg + 1'b1;
                            end
                        end
                        S_XFER: begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                            if (rw_reg && byte_cnt_reg != BYTES_LAST)
                                bus.wr_ready <= 1'b1;
                        end
                        S_WAIT_DONE: begin
                            if (!status_bit_reg) begin
                                state_reg <= S_DONE;
                                bus.busy  <= 1'b0;
                                bus.done  <= 1'b1;
                            end else if (poll_cnt_reg == POLL_LAST) begin
                                state_reg <= S_ERROR;
                                bus.busy  <= 1'b0;
                                bus.error <= 1'b1;
                            end else begin
                                poll_cnt_reg <= poll_cnt_reg + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ide_host_ctrl.sv
// Bench for ide_host_ctrl: a behavioural IDE device, scoreboarded register writes, read stream
// and done/error events, plus directed read/write/backpressure/timeout/reset scenarios.
module tb_ide_host_ctrl;
    localparam int AC = 2;
    localparam int SB = 512;
    localparam int PL = 8;

    logic clk;
    logic arst_n;
    ide_host_ctrl_if bus_if();

    ide_host_ctrl #(.ACCESS_CYCLES(AC), .SECTOR_BYTES(SB), .POLL_LIMIT(PL)) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected value 0x%0h", name, act);
    endtask

    function automatic logic [7:0] img(input int k);
        img = 8'((k * 7 + 3) & 255);
    endfunction

    // Device model: registers 3..5/7, data port 0, status bit3 (DRQ)
    logic [7:0] dev_mem [0:2047];
    bit         mem_ready = 0;
    logic [7:0] r_lba0, r_lba1, r_lba2;
    int         dev_ptr, dev_phase, pre_cnt, post_cnt;
    int         dev_stat_reads, dev_data_rd, dev_data_wr;
    logic       oe_d = 1'b1, we_d = 1'b1;
    bit         never_drq;
    logic       drq;

    always_comb drq = !never_drq && ((dev_phase == 1 && pre_cnt >= 3) || dev_phase == 2 ||
                                     (dev_phase == 3 && post_cnt < 2));
    always_comb bus_if.bus_din = (bus_if.address == 3'd7) ? {4'b0, drq, 3'b0}
                                                          : dev_mem[dev_ptr[10:0]];

    always @(posedge clk) begin
        oe_d <= bus_if.oe_n;
        we_d <= bus_if.we_n;
        if (!mem_ready) begin
            for (int k = 0; k < 2048; k++) dev_mem[k] <= img(k);
            mem_ready <= 1'b1;
            dev_phase <= 0;
        end else begin
            if (!oe_d && bus_if.oe_n) begin
                if (bus_if.address == 3'd7) begin
                    dev_stat_reads <= dev_stat_reads + 1;
                    if (dev_phase == 1) pre_cnt <= pre_cnt + 1;
                    else if (dev_phase == 3) post_cnt <= post_cnt + 1;
                end else if (bus_if.address == 3'd0) begin
                    dev_ptr     <= dev_ptr + 1;
                    dev_data_rd <= dev_data_rd + 1;
                    dev_phase   <= (dev_data_rd + dev_data_wr == SB - 1) ? 3 : 2;
                end
            end
            if (!we_d && bus_if.we_n) begin
                case (bus_if.address)
                    3'd3: r_lba0 <= bus_if.bus_dout;
                    3'd4: r_lba1 <= bus_if.bus_dout;
                    3'd5: r_lba2 <= bus_if.bus_dout;
                    3'd7: begin
                        dev_ptr        <= int'({r_lba2, r_lba1, r_lba0});
                        dev_phase      <= 1;
                        pre_cnt        <= 0;
                        post_cnt       <= 0;
                        dev_stat_reads <= 0;
                        dev_data_rd    <= 0;
                        dev_data_wr    <= 0;
                    end
                    3'd0: begin
                        dev_mem[dev_ptr[10:0]] <= bus_if.bus_dout;
                        dev_ptr     <= dev_ptr + 1;
                        dev_data_wr <= dev_data_wr + 1;
                        dev_phase   <= (dev_data_rd + dev_data_wr == SB - 1) ? 3 : 2;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write-stream source: incrementing bytes 0..SB-1
    bit wr_en;
    bit wr_fire;
    int wr_idx;
    always @(posedge clk) begin
        wr_fire = bus_if.wr_valid && bus_if.wr_ready;
        #1;
        if (!wr_en) wr_idx = 0;
        else if (wr_fire) wr_idx++;
        bus_if.wr_valid = wr_en && (wr_idx < SB);
        bus_if.wr_data  = wr_idx[7:0];
    end

    // Scoreboards
    logic [10:0] wq[$];
    logic [7:0]  rd_exp_q[$];
    logic [7:0]  evt_q[$];
    int          rd_acc_cnt = 0;
    int          ce_run = 0, st_run = 0;
    logic        prev_we = 1'b1;

    always @(negedge clk) begin
        if (!arst_n) begin
            ce_run  = 0;
            st_run  = 0;
            prev_we = 1'b1;
        end else begin
            if (!bus_if.ce_n) ce_run++;
            else if (ce_run != 0) begin
                chk("access_len", ce_run, AC + 2);
                ce_run = 0;
            end
            if (!bus_if.oe_n || !bus_if.we_n) st_run++;
            else if (st_run != 0) begin
                chk("strobe_len", st_run, AC);
                st_run = 0;
            end
            if (!bus_if.oe_n && !bus_if.we_n) flag("strobe_overlap", 1);
            if (!prev_we && bus_if.we_n && bus_if.address != 3'd0) begin
                if (wq.size() == 0) flag("unexpected_reg_write", {bus_if.address, bus_if.bus_dout});
                else chk("reg_write", {bus_if.address, bus_if.bus_dout}, wq.pop_front());
            end
            prev_we = bus_if.we_n;
            if (bus_if.rd_valid && bus_if.rd_ready) begin
                rd_acc_cnt++;
                if (rd_exp_q.size() == 0) flag("unexpected_rd_byte", bus_if.rd_data);
                else chk("rd_data", bus_if.rd_data, rd_exp_q.pop_front());
            end
            if (bus_if.done || bus_if.error) begin
                if (evt_q.size() == 0) flag("unexpected_event", {bus_if.done, bus_if.error});
                else chk("event_kind", bus_if.done ? 8'h44 : 8'h45, evt_q.pop_front());
                chk("busy_at_event", bus_if.busy, 0);
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_ce_n"}, bus_if.ce_n, 1);
        chk({tag, "_oe_n"}, bus_if.oe_n, 1);
        chk({tag, "_we_n"}, bus_if.we_n, 1);
        chk({tag, "_address"}, bus_if.address, 0);
        chk({tag, "_bus_dout"}, bus_if.bus_dout, 0);
        chk({tag, "_busy"}, bus_if.busy, 0);
        chk({tag, "_done"}, bus_if.done, 0);
        chk({tag, "_error"}, bus_if.error, 0);
        chk({tag, "_rd_valid"}, bus_if.rd_valid, 0);
        chk({tag, "_wr_ready"}, bus_if.wr_ready, 0);
    endtask

    task automatic issue(input logic rw_i, input logic [23:0] lba_i, input logic exp_err);
        wq.push_back({3'd3, lba_i[7:0]});
        wq.push_back({3'd4, lba_i[15:8]});
        wq.push_back({3'd5, lba_i[23:16]});
        wq.push_back({3'd7, rw_i ? 8'h30 : 8'h20});
        evt_q.push_back(exp_err ? 8'h45 : 8'h44);
        if (!rw_i && !exp_err)
            for (int i = 0; i < SB; i++) rd_exp_q.push_back(img(int'(lba_i) + i));
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.rw = rw_i; bus_if.lba = lba_i;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("busy_after_start", bus_if.busy, 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((evt_q.size() != 0 || bus_if.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_finished_in_budget"}, n < budget, 1);
        chk({name, "_rd_queue_drained"}, rd_exp_q.size(), 0);
        chk({name, "_reg_writes_drained"}, wq.size(), 0);
    endtask

    task automatic wait_bytes(input string name, input int base, input int cnt);
        int n = 0;
        while (rd_acc_cnt - base < cnt && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_bytes_reached"}, n < 4000, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bad, seen, drops, changes, oe_after, quiet;
        logic [7:0] held;
        arst_n = 1'b0;
        bus_if.start = 1'b0; bus_if.rw = 1'b0; bus_if.lba = '0; bus_if.rd_ready = 1'b1;
        wr_en = 0; never_drq = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        arst_n = 1'b1;

        // Read sector at LBA 0x000123
        issue(1'b0, 24'h000123, 1'b0);
        wait_idle("read1", 6000);
        chk("read1_bus_reads", dev_data_rd, SB);
        $display("read lba=0x000123 done, %0d bytes streamed", rd_acc_cnt);

        // Read with consumer stall after byte 5
        base = rd_acc_cnt;
        issue(1'b0, 24'h000050, 1'b0);
        wait_bytes("bp", base, 5);
        @(posedge clk); #1;
        bus_if.rd_ready = 1'b0;
        seen = 0; drops = 0; changes = 0; oe_after = 0; held = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.rd_valid) begin
                if (seen == 0) begin seen = 1; held = bus_if.rd_data; end
                else if (bus_if.rd_data !== held) changes++;
            end else if (seen != 0) drops++;
            if (seen != 0 && !bus_if.oe_n) oe_after++;
        end
        chk("bp_valid_seen", seen, 1);
        chk("bp_held_byte", held, img(24'h50 + 5));
        chk("bp_valid_drops", drops, 0);
        chk("bp_data_changes", changes, 0);
        chk("bp_oe_during_stall", oe_after, 0);
        @(posedge clk); #1;
        bus_if.rd_ready = 1'b1;
        wait_idle("bp", 6000);
        $display("backpressure read lba=0x000050 done");

        // Status never ready: poll timeout
        never_drq = 1;
        issue(1'b0, 24'h000000, 1'b1);
        wait_idle("timeout", 500);
        chk("timeout_status_reads", dev_stat_reads, PL);
        chk("timeout_data_accesses", dev_data_rd + dev_data_wr, 0);
        never_drq = 0;
        $display("timeout command done, %0d status reads", dev_stat_reads);

        // Write sector at LBA 0x000010 from incrementing stream
        wr_en = 1;
        issue(1'b1, 24'h000010, 1'b0);
        wait_idle("write", 6000);
        wr_en = 0;
        bad = 0;
        for (int i = 0; i < SB; i++)
            if (dev_mem[16 + i] !== 8'(i)) bad++;
        chk("write_mem_mismatches", bad, 0);
        chk("write_data_pulses", dev_data_wr, SB);
        chk("write_stream_consumed", wr_idx, SB);
        $display("write lba=0x000010 done, %0d data writes", dev_data_wr);

        // Reset during a data-port read strobe
        base = rd_acc_cnt;
        issue(1'b0, 24'h000300, 1'b0);
        wait_bytes("rst", base, 3);
        begin
            int n = 0;
            while (!(bus_if.oe_n == 1'b0 && bus_if.address == 3'd0) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rst_found_strobe", n < 100, 1);
        end
        #2 arst_n = 1'b0;
        #1;
        chk("rst_async_ce_n", bus_if.ce_n, 1);
        chk("rst_async_oe_n", bus_if.oe_n, 1);
        chk("rst_async_we_n", bus_if.we_n, 1);
        chk("rst_async_busy", bus_if.busy, 0);
        rd_exp_q.delete();
        evt_q.delete();
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        check_idle("post_reset");
        $display("reset mid-transfer applied");

        // Fresh read after reset, with a start pulse while busy
        base = rd_acc_cnt;
        issue(1'b0, 24'h000400, 1'b0);
        wait_bytes("busy_start", base, 10);
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.rw = 1'b1; bus_if.lba = 24'hABCDEF;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_idle("post_reset_read", 6000);
        chk("post_reset_read_bytes", rd_acc_cnt - base, SB);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus_if.ce_n) quiet++;
        end
        chk("no_access_after_done", quiet, 0);
        chk("no_extra_event", evt_q.size(), 0);
        $display("read lba=0x000400 with ignored start done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
